mips_fetch_unit: RTL

Instruction fetch stage placed directly upstream of the single-cycle MIPS datapath. Generates sequential word addresses, issues one request at a time to instruction memory over a req/gnt/rvalid handshake, buffers returned words with their PCs in a small prefetch FIFO, and presents them to decode over a valid/ready interface. A redirect from branch or jump resolution flushes the buffer and restarts fetch at the target.

---
 rtl/mips_fetch_pkg.sv | 24 ++
 rtl/mips_fetch_unit_if.sv | 26 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/mips_fetch_unit.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch unit.
package mips_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Instruction-memory request/response bus: req/gnt handshake plus rvalid data return.
interface mips_fetch_unit_if;

  logic                           imem_req;
  logic [mips_fetch_pkg::XLEN-1:0] imem_addr;
  logic                           imem_gnt;
  logic                           imem_rvalid;
  logic [mips_fetch_pkg::XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, inst} entries with flush; push and pop may coincide even when full.
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  output fetch_entry_t           head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; empty_o gates the head so stale words never reach decode.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS fetch stage: one outstanding imem request, prefetch FIFO, redirect flush.
// Optional performance counters are built when MIPS_FETCH_PERF_EN is defined.
module mips_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mips_fetch_unit_if.master    imem,
  input  logic                 redirect_valid_i,
  input  logic [XLEN-1:0]      redirect_pc_i,
  output logic                 inst_valid_o,
  input  logic                 inst_ready_i,
  output logic [XLEN-1:0]      inst_data_o,
  output logic [XLEN-1:0]      inst_pc_o,
  output logic [XLEN-1:0]      pc_out_o
`ifdef MIPS_FETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetched_o,
  output logic [31:0]          perf_stall_o
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e     state_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  req_pc_q;

  fetch_entry_t     head;
  fetch_entry_t     push_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [CW-1:0]    count_after_push;
  logic             push;
  logic             pop_eff;
  logic             room_after_push;

  // Redirect outranks both push and pop in the same cycle.
  assign pop_eff = inst_valid_o && inst_ready_i && !redirect_valid_i;
  assign push    = (state_q == WAIT) && imem.imem_rvalid && !redirect_valid_i;

  assign push_data.pc   = req_pc_q;
  assign push_data.inst = imem.imem_rdata;

  assign count_after_push = fifo_count + CW'(1) - CW'(pop_eff);
  assign room_after_push  = (count_after_push < CW'(DEPTH));

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_valid_i),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop_eff),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else if (redirect_valid_i) begin
      pc_q <= align_word(redirect_pc_i);
      // A response still owed by memory must be swallowed before refetching.
      if ((state_q == REQ && imem.imem_gnt) ||
          ((state_q == WAIT || state_q == DROP) && !imem.imem_rvalid))
        state_q <= DROP;
      else
        state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (!fifo_full) state_q <= REQ;
        REQ: begin
          if (imem.imem_gnt) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + PC_INC;
            state_q  <= WAIT;
          end
        end
        WAIT: if (imem.imem_rvalid) state_q <= room_after_push ? REQ : IDLE;
        DROP: if (imem.imem_rvalid) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem.imem_req  = (state_q == REQ);
  assign imem.imem_addr = pc_q;
  assign pc_out_o       = pc_q;

  assign inst_valid_o = !fifo_empty;
  assign inst_data_o  = head.inst;
  assign inst_pc_o    = head.pc;

`ifdef MIPS_FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (pop_eff)                       perf_fetched_q <= perf_fetched_q + 32'd1;
      if (inst_ready_i && !inst_valid_o) perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_stall_o   = perf_stall_q;
`endif

endmodule
